// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI master/slave pair.
package spi_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned CLK_DIV_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Bundle of the SPI master's word handshake and serial pins.
interface spi_master_if #(
  parameter int unsigned DATA_W = spi_pkg::DATA_W_DEF
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_cs_n;

  modport master (
    input  tx_data, tx_valid, spi_miso,
    output tx_ready, rx_data, rx_valid, spi_clk, spi_mosi, spi_cs_n
  );

  modport slave (
    output tx_data, tx_valid, spi_miso,
    input  tx_ready, rx_data, rx_valid, spi_clk, spi_mosi, spi_cs_n
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator; counts only while enabled, parks at zero otherwise.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_sys,
  input  logic rst_sys,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (rst_sys || !en) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one word per frame, MSB first, cs_n framed with lead/trail gaps.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic         clk_sys,
  input  logic         rst_sys,
  spi_master_if.master bus
);

  localparam int unsigned HALF_N = 2 * DATA_W;
  localparam int unsigned HC_W   = $clog2(HALF_N);

  spi_state_e        state, state_n;
  logic [DATA_W-1:0] tx_sr, tx_sr_n;
  logic [DATA_W-1:0] rx_sr, rx_sr_n;
  logic [DATA_W-1:0] rx_data_q, rx_data_n;
  logic [HC_W-1:0]   half_cnt, half_cnt_n;
  logic              sclk_q, sclk_n;
  logic              mosi_q, mosi_n;
  logic              cs_n_q, cs_n_n;
  logic              rx_valid_q, rx_valid_n;
  logic              tick_c;
  logic              tx_ready_c;
  logic              accept_c;
  logic              last_half_c;

  assign tx_ready_c  = (state == IDLE) && !rst_sys;
  assign accept_c    = bus.tx_valid && tx_ready_c;
  assign last_half_c = (half_cnt == HC_W'(HALF_N - 1));

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .en      (state != IDLE),
    .tick_c  (tick_c)
  );

  // Next-state and next-output decode; every register holds unless a tick or accept moves it.
  always_comb begin
    state_n    = state;
    tx_sr_n    = tx_sr;
    rx_sr_n    = rx_sr;
    rx_data_n  = rx_data_q;
    half_cnt_n = half_cnt;
    sclk_n     = sclk_q;
    mosi_n     = mosi_q;
    cs_n_n     = cs_n_q;
    rx_valid_n = 1'b0;

    unique case (state)
      IDLE: begin
        sclk_n = 1'b0;
        mosi_n = 1'b0;
        cs_n_n = 1'b1;
        if (accept_c) begin
          state_n    = LEAD;
          tx_sr_n    = bus.tx_data;
          rx_sr_n    = '0;
          half_cnt_n = '0;
          mosi_n     = bus.tx_data[DATA_W-1];
          cs_n_n     = 1'b0;
        end
      end

      LEAD: begin
        if (tick_c) begin
          state_n    = SHIFT;
          half_cnt_n = '0;
        end
      end

      SHIFT: begin
        if (tick_c) begin
          half_cnt_n = half_cnt + HC_W'(1);
          if (!half_cnt[0]) begin
            // Low phase ends: rising edge, sample miso on this same clk_sys edge.
            sclk_n  = 1'b1;
            rx_sr_n = {rx_sr[DATA_W-2:0], bus.spi_miso};
          end else begin
            sclk_n = 1'b0;
            if (last_half_c) begin
              state_n    = TRAIL;
              half_cnt_n = '0;
            end else begin
              tx_sr_n = {tx_sr[DATA_W-2:0], 1'b0};
              mosi_n  = tx_sr[DATA_W-2];
            end
          end
        end
      end

      TRAIL: begin
        if (tick_c) begin
          state_n    = IDLE;
          cs_n_n     = 1'b1;
          mosi_n     = 1'b0;
          rx_valid_n = 1'b1;
          rx_data_n  = rx_sr;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state      <= IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      half_cnt   <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state      <= state_n;
      tx_sr      <= tx_sr_n;
      rx_sr      <= rx_sr_n;
      rx_data_q  <= rx_data_n;
      half_cnt   <= half_cnt_n;
      sclk_q     <= sclk_n;
      mosi_q     <= mosi_n;
      cs_n_q     <= cs_n_n;
      rx_valid_q <= rx_valid_n;
    end
  end

  assign bus.tx_ready = tx_ready_c;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.spi_clk  = sclk_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.spi_cs_n = cs_n_q;

  a_clk_low_when_deselected: assert property (
    @(posedge clk_sys) disable iff (rst_sys) cs_n_q |-> !sclk_q);

  a_rx_valid_single: assert property (
    @(posedge clk_sys) disable iff (rst_sys) rx_valid_q |=> !rx_valid_q);

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default instance with loopback/tie-high miso, CLK_DIV=2 instance with a slave model.
module tb_spi_master;

  logic       clk_sys = 1'b0;
  logic       rst_sys;
  logic       miso_tie;
  logic       miso2;
  logic [7:0] slv_word;
  logic [7:0] slv_sr;
  logic [7:0] slv_rx;
  int         total = 0;
  int         bad   = 0;

  spi_master_if #(.DATA_W(8)) bus ();
  spi_master_if #(.DATA_W(8)) bus2 ();

  assign bus.spi_miso  = miso_tie ? 1'b1 : bus.spi_mosi;
  assign bus2.spi_miso = miso2;

  spi_master #(.DATA_W(8), .CLK_DIV(4)) u_dut (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .bus     (bus)
  );

  spi_master #(.DATA_W(8), .CLK_DIV(2)) u_dut2 (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .bus     (bus2)
  );

  always #5 clk_sys = ~clk_sys;

  // Mode-0 slave: first bit on cs_n fall, shift out on spi_clk fall, sample on rise.
  always @(negedge bus2.spi_cs_n) begin
    slv_sr = slv_word;
    miso2  = slv_sr[7];
  end
  always @(posedge bus2.spi_clk) begin
    if (bus2.spi_cs_n == 1'b0) slv_rx = {slv_rx[6:0], bus2.spi_mosi};
  end
  always @(negedge bus2.spi_clk) begin
    if (bus2.spi_cs_n == 1'b0) begin
      slv_sr = {slv_sr[6:0], 1'b0};
      miso2  = slv_sr[7];
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Pulse tx_valid for one cycle with word d and observe the default instance until rx_valid.
  task automatic frame1(input logic [7:0] d, output int lat, output logic [7:0] rx,
                        output logic [7:0] mbits, output int rises, output int mosi_ones,
                        output logic [2:0] lead);
    logic prev;
    prev = 1'b0; lat = -1; rx = '0; mbits = '0; rises = 0; mosi_ones = 0; lead = '0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (n == 1) begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~d;
        lead = {bus.spi_cs_n, bus.spi_clk, bus.spi_mosi};
      end
      if (bus.spi_clk && !prev) begin
        mbits = {mbits[6:0], bus.spi_mosi};
        rises++;
      end
      prev = bus.spi_clk;
      if (!bus.spi_cs_n && bus.spi_mosi) mosi_ones++;
      if (bus.rx_valid) begin
        lat = n;
        rx  = bus.rx_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_sys = 1'b1;
    repeat (3) step();
    total++; if (bus.spi_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", bus.spi_cs_n); end
    total++; if (bus.spi_clk !== 1'b0) begin bad++; $display("FAIL reset_spi_clk: got %b want 0", bus.spi_clk); end
    total++; if (bus.spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", bus.spi_mosi); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready: got %b want 0", bus.tx_ready); end
    rst_sys = 1'b0;
    #1;
    total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL post_reset_tx_ready: got %b want 1", bus.tx_ready); end
    step();
    total++; if (bus2.tx_ready !== 1'b1) begin bad++; $display("FAIL post_reset_tx_ready2: got %b want 1", bus2.tx_ready); end
  endtask

  task automatic test_loopback_a5();
    int lat, rises, ones;
    logic [7:0] rx, mbits;
    logic [2:0] lead;
    miso_tie = 1'b0;
    frame1(8'hA5, lat, rx, mbits, rises, ones, lead);
    total++; if (lead !== 3'b001) begin bad++; $display("FAIL a5_lead{cs_n,clk,mosi}: got %b want 001", lead); end
    total++; if (lat !== 73) begin bad++; $display("FAIL a5_latency: got %0d want 73", lat); end
    total++; if (rx !== 8'hA5) begin bad++; $display("FAIL a5_rx_data: got %h want a5", rx); end
    total++; if (mbits !== 8'hA5) begin bad++; $display("FAIL a5_mosi_seq: got %b want 10100101", mbits); end
    total++; if (rises !== 8) begin bad++; $display("FAIL a5_clk_rises: got %0d want 8", rises); end
    total++; if (bus.spi_cs_n !== 1'b1) begin bad++; $display("FAIL a5_cs_n_at_valid: got %b want 1", bus.spi_cs_n); end
    total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL a5_ready_at_valid: got %b want 1", bus.tx_ready); end
    step();
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL a5_rx_valid_width: got %b want 0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'hA5) begin bad++; $display("FAIL a5_rx_data_hold: got %h want a5", bus.rx_data); end
    total++; if (bus.spi_mosi !== 1'b0) begin bad++; $display("FAIL a5_idle_mosi: got %b want 0", bus.spi_mosi); end
  endtask

  task automatic test_miso_high();
    int lat, rises, ones;
    logic [7:0] rx, mbits;
    logic [2:0] lead;
    miso_tie = 1'b1;
    frame1(8'h00, lat, rx, mbits, rises, ones, lead);
    total++; if (lat !== 73) begin bad++; $display("FAIL ones_latency: got %0d want 73", lat); end
    total++; if (rx !== 8'hFF) begin bad++; $display("FAIL ones_rx_data: got %h want ff", rx); end
    total++; if (ones !== 0) begin bad++; $display("FAIL ones_mosi_high_cycles: got %0d want 0", ones); end
    miso_tie = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int nvalid, csn_hi, viol, t1, t2;
    logic [7:0] r1, r2;
    nvalid = 0; csn_hi = 0; viol = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (n == 20)  bus.tx_data = 8'hFF;
      if (n == 60)  bus.tx_data = 8'hC3;
      if (n == 74)  bus.tx_valid = 1'b0;
      if (n == 100) bus.tx_data = 8'h00;
      if (bus.spi_cs_n && bus.spi_clk) viol++;
      if (bus.rx_valid) begin
        nvalid++;
        if (nvalid == 1) begin t1 = n; r1 = bus.rx_data; end
        if (nvalid == 2) begin t2 = n; r2 = bus.rx_data; break; end
      end
      if (bus.spi_cs_n) csn_hi++;
    end
    total++; if (t1 !== 73) begin bad++; $display("FAIL b2b_first_valid_cycle: got %0d want 73", t1); end
    total++; if (r1 !== 8'h3C) begin bad++; $display("FAIL b2b_first_word: got %h want 3c", r1); end
    total++; if (t2 !== 146) begin bad++; $display("FAIL b2b_second_valid_cycle: got %0d want 146", t2); end
    total++; if (r2 !== 8'hC3) begin bad++; $display("FAIL b2b_second_word: got %h want c3", r2); end
    total++; if (csn_hi !== 1) begin bad++; $display("FAIL b2b_cs_n_gap: got %0d want 1", csn_hi); end
    total++; if (viol !== 0) begin bad++; $display("FAIL b2b_clk_high_deselected: got %0d want 0", viol); end
    step();
  endtask

  task automatic test_reset_abort();
    int nvalid;
    nvalid = 0;
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    for (int n = 1; n <= 29; n++) begin
      step();
      if (n == 1) bus.tx_valid = 1'b0;
    end
    step();
    rst_sys = 1'b1;
    #1;
    total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_in_reset: got %b want 0", bus.tx_ready); end
    step();
    rst_sys = 1'b0;
    #1;
    total++; if (bus.spi_cs_n !== 1'b1) begin bad++; $display("FAIL abort_cs_n: got %b want 1", bus.spi_cs_n); end
    total++; if (bus.spi_clk !== 1'b0) begin bad++; $display("FAIL abort_spi_clk: got %b want 0", bus.spi_clk); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL abort_rx_data: got %h want 00", bus.rx_data); end
    total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL abort_ready_after: got %b want 1", bus.tx_ready); end
    for (int n = 0; n < 100; n++) begin
      if (bus.rx_valid) nvalid++;
      step();
    end
    total++; if (nvalid !== 0) begin bad++; $display("FAIL abort_no_rx_valid: got %0d want 0", nvalid); end
  endtask

  task automatic test_div2_slave();
    int r[8];
    int f[8];
    int nr, nf, lat, bad_ph;
    logic prev;
    logic [7:0] rxw;
    for (int i = 0; i < 8; i++) begin r[i] = 0; f[i] = 0; end
    nr = 0; nf = 0; lat = -1; prev = 1'b0; rxw = '0; bad_ph = 0;
    slv_word      = 8'h5E;
    slv_rx        = 8'h00;
    bus2.tx_data  = 8'h96;
    bus2.tx_valid = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 1) bus2.tx_valid = 1'b0;
      if (bus2.spi_clk && !prev) begin if (nr < 8) r[nr] = n; nr++; end
      if (!bus2.spi_clk && prev) begin if (nf < 8) f[nf] = n; nf++; end
      prev = bus2.spi_clk;
      if (bus2.rx_valid) begin lat = n; rxw = bus2.rx_data; break; end
    end
    for (int i = 0; i < 8; i++) if (f[i] - r[i] != 2) bad_ph++;
    for (int i = 0; i < 7; i++) if (r[i+1] - f[i] != 2) bad_ph++;
    total++; if (lat !== 37) begin bad++; $display("FAIL div2_latency: got %0d want 37", lat); end
    total++; if (nr !== 8) begin bad++; $display("FAIL div2_rises: got %0d want 8", nr); end
    total++; if (nf !== 8) begin bad++; $display("FAIL div2_falls: got %0d want 8", nf); end
    total++; if (r[0] !== 5) begin bad++; $display("FAIL div2_first_rise_cycle: got %0d want 5", r[0]); end
    total++; if (bad_ph !== 0) begin bad++; $display("FAIL div2_phase_len: got %0d bad phases want 0", bad_ph); end
    total++; if (rxw !== 8'h5E) begin bad++; $display("FAIL div2_master_rx: got %h want 5e", rxw); end
    total++; if (slv_rx !== 8'h96) begin bad++; $display("FAIL div2_slave_rx: got %h want 96", slv_rx); end
  endtask

  initial begin
    rst_sys       = 1'b1;
    miso_tie      = 1'b0;
    miso2         = 1'b0;
    slv_word      = 8'h00;
    slv_sr        = 8'h00;
    slv_rx        = 8'h00;
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;
    bus2.tx_data  = 8'h00;
    bus2.tx_valid = 1'b0;
    test_reset();
    test_loopback_a5();
    test_miso_high();
    test_back_to_back();
    test_reset_abort();
    test_div2_slave();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 8: transfer word width in bits.
REQ-002 Parameter CLK_DIV, default 4: spi_clk half-period in clk_sys cycles; legal range >= 2.
REQ-003 clk_sys  input  1  system clock; the only clock; all logic on its rising edge.
REQ-004 rst_sys  input  1  synchronous, active-high reset.
REQ-005 tx_data  input  DATA_W  word to transmit; sampled only on the accept cycle.
REQ-006 tx_valid  input  1  request to start a transfer.
REQ-007 tx_ready  output  1  high when a new transfer can be accepted.
REQ-008 rx_data  output  DATA_W  word received on spi_miso; held until the next rx_valid.
REQ-009 rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-010 spi_clk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0), driven from a register.
REQ-011 spi_mosi  output  1  serial data out, MSB first, driven from a register.
REQ-012 spi_miso  input  1  serial data in from the spi_slave peer.
REQ-013 spi_cs_n  output  1  active-low frame select, driven from a register.

Function
REQ-014 FSM states: IDLE, LEAD, SHIFT, TRAIL.
REQ-015 tx_ready SHALL equal (state==IDLE) and SHALL be low while rst_sys is high.
REQ-016 Accept occurs on the cycle with tx_valid && tx_ready. At accept cycle T the block SHALL load tx_data into the shift register and enter LEAD at T+1.
REQ-017 LEAD: CLK_DIV cycles; spi_cs_n=0, spi_clk=0, spi_mosi=tx_data[DATA_W-1].
REQ-018 SHIFT: 2*DATA_W half-periods of CLK_DIV cycles each, starting with spi_clk low. spi_clk toggles at each half-period boundary.
REQ-019 spi_miso SHALL be sampled into the rx shift register (LSB-in) on the clk_sys edge at which spi_clk goes 0->1.
REQ-020 spi_mosi SHALL advance to the next lower bit on each spi_clk 1->0 transition, except after the final bit.
REQ-021 TRAIL: CLK_DIV cycles; spi_clk=0, spi_cs_n=0, spi_mosi holds the last bit.
REQ-022 Leaving TRAIL enters IDLE. On that first IDLE cycle the block SHALL drive spi_cs_n=1, rx_valid=1 for exactly one cycle, and rx_data = the assembled word.
REQ-023 Latency: rx_valid SHALL assert at T + (2*DATA_W+2)*CLK_DIV + 1. With defaults this is T+73.
REQ-024 tx_valid while not in IDLE SHALL be ignored; no queuing occurs and tx_data is not sampled.
REQ-025 Back-to-back transfers: tx_ready is high in the rx_valid cycle. An accept in that cycle SHALL start LEAD on the next cycle, giving a minimum spi_cs_n high time of 1 cycle.
REQ-026 spi_clk SHALL be low whenever spi_cs_n is high. Exactly DATA_W rising edges SHALL occur per frame.
REQ-027 In IDLE, spi_mosi SHALL be 0.

Reset
REQ-028 While rst_sys is high at a clk_sys edge: state=IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, rx_valid=0, rx_data=0, all counters=0.
REQ-029 Reset asserted mid-frame SHALL abort the transfer on the next edge. No rx_valid SHALL be produced for the aborted frame.
REQ-030 tx_ready SHALL rise on the first cycle after rst_sys deasserts.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state enum and the default DATA_W/CLK_DIV constants; spi_slave shares the same package.
REQ-032 One sub-module, spi_clk_div, SHALL produce a half-period tick every CLK_DIV cycles.
  - It is enabled outside IDLE and cleared on IDLE/reset.
  - The FSM, shifters and bit counter live in spi_master.

Verification
REQ-033 Single transfer, defaults, loopback spi_miso=spi_mosi, tx_data=8'hA5 accepted at T:
  - spi_mosi sequence is 1,0,1,0,0,1,0,1.
  - 8 spi_clk rises occur.
  - rx_valid pulses at T+73 with rx_data=8'hA5.
REQ-034 spi_miso tied to 1, tx_data=8'h00 -> rx_data=8'hFF; spi_mosi stays 0 throughout the frame.
REQ-035 tx_valid held high continuously with data 8'h3C, then 8'hC3:
  - Two frames separated by exactly one spi_cs_n-high cycle.
  - tx_data changes applied during a frame are ignored.
REQ-036 rst_sys pulsed for 1 cycle at T+30 of a frame:
  - Next cycle spi_cs_n=1 and spi_clk=0.
  - No rx_valid occurs.
  - tx_ready=1 on the following cycle.
REQ-037 CLK_DIV=2 instance with spi_slave connected:
  - spi_clk high and low phases are each exactly 2 cycles.
  - rx_valid at T+37.
  - Data matches the spi_slave model.
